qspi_slave: RTL and testbench

QSPI_SLAVE -- requirements
Module: qspi_slave

---
 rtl/qspi_pkg.sv | 79 +++++++
 rtl/qspi_sync.sv | 35 +++
 rtl/qspi_slave.sv | 240 ++++++++++++++++++++++++
 tb/tb_qspi_slave.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI slave: FSM states, opcodes, status bits, lane helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_RESP,
        ST_IGNORE
    } state_t;

    // Data lane widths used by the read/write data phases
    typedef enum logic [1:0] {
        LANE_1,
        LANE_2,
        LANE_4
    } lanes_t;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR1 = 8'h05;
    localparam logic [7:0] OP_RDID  = 8'h9F;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_DOR   = 8'h3B;
    localparam logic [7:0] OP_QPP   = 8'h32;
    localparam logic [7:0] OP_QOR   = 8'h6B;

    // Status register bit positions
    localparam int STAT_WIP_BIT = 0;
    localparam int STAT_WEL_BIT = 1;

    function automatic lanes_t op_lanes(input logic [7:0] op);
        case (op)
            OP_DOR:         return LANE_2;
            OP_QOR, OP_QPP: return LANE_4;
            default:        return LANE_1;
        endcase
    endfunction

    function automatic logic [2:0] lane_bits(input lanes_t l);
        case (l)
            LANE_2:  return 3'd2;
            LANE_4:  return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [3:0] lane_oe(input lanes_t l);
        case (l)
            LANE_2:  return 4'b0011;
            LANE_4:  return 4'b1111;
            default: return 4'b0010;
        endcase
    endfunction

    // Top bits of v placed on the lanes that carry them (single lane uses io[1])
    function automatic logic [3:0] lane_drive(input lanes_t l, input logic [7:0] v);
        case (l)
            LANE_2:  return {2'b00, v[7:6]};
            LANE_4:  return v[7:4];
            default: return {2'b00, v[7], 1'b0};
        endcase
    endfunction

    function automatic logic [7:0] status_byte(input logic wel);
        logic [7:0] s;
        s               = 8'h00;
        s[STAT_WEL_BIT] = wel;
        s[STAT_WIP_BIT] = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/qspi_sync.sv
// Two-flop synchroniser with an extra history flop for rise/fall detection.
// Latency: 2 clk to dout, edges flagged in the same cycle dout changes.
// Backpressure: none; free-running sampler.
module qspi_sync #(
    parameter int             W       = 6,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] meta;
    logic [W-1:0] prev;

    // Metastability flop, synchronised output and one cycle of history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            dout <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= din;
            dout <= meta;
            prev <= dout;
        end
    end

    assign rise = dout & ~prev;
    assign fall = ~dout & prev;

endmodule

// File: rtl/qspi_slave.sv
// QSPI flash-style slave bridging SPI/dual/quad commands to a byte memory port.
// Latency: output lanes update ~3 clk after SCLK fall; io sampled ~3 clk after SCLK rise.
// Backpressure: none; memory must return read data one clk after mem_re_o.
module qspi_slave
    import qspi_pkg::*;
#(
    parameter logic [23:0] ID_VAL = 24'h01_20_18,
    parameter int          MEM_AW = 24
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sclk_i,
    input  logic              cs_ni,
    inout  wire  [3:0]        io,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i
);

    logic [5:0]  s_q;
    logic [5:0]  s_rise;
    logic [5:0]  s_fall;
    logic        cs_n;
    logic        cs_fall;
    logic        sck_rise;
    logic        sck_fall;
    logic [3:0]  io_in;

    state_t      state;
    state_t      nxt;
    logic [7:0]  cmd;
    logic [4:0]  cnt;
    logic [1:0]  ridx;
    logic [23:0] sh;
    logic [7:0]  osh;
    logic [7:0]  nxt_byte;
    logic        rd_cap;
    logic        wel;
    logic        wr_txn;
    logic        armed;
    logic [1:0]  settle;
    logic [3:0]  oe;
    logic [3:0]  out;

    lanes_t      lanes;
    logic [2:0]  nb;
    logic [7:0]  cmd_byte;
    logic [23:0] addr_full;
    logic [7:0]  wr_next;
    logic [2:0]  bpos_next;
    logic [7:0]  resp_byte;
    logic [7:0]  rd_val;

    // Order: cs_n, sclk, io[3:0]; control lines reset high, data lines low
    qspi_sync #(
        .W       (6),
        .RST_VAL (6'b110000)
    ) u_sync (
        .clk  (clk_i),
        .rst  (rst_i),
        .din  ({cs_ni, sclk_i, io}),
        .dout (s_q),
        .rise (s_rise),
        .fall (s_fall)
    );

    assign cs_n     = s_q[5];
    assign cs_fall  = s_fall[5];
    assign sck_rise = s_rise[4];
    assign sck_fall = s_fall[4];
    assign io_in    = s_q[3:0];

    logic unused_bits;
    assign unused_bits = ^{s_rise[5], s_rise[3:0], s_fall[3:0], sh[23]};

    for (genvar i = 0; i < 4; i++) begin : g_io
        assign io[i] = oe[i] ? out[i] : 1'bz;
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= nxt;
    end

    // Next-state: cs_n high wins from any state; otherwise phase completions advance
    always_comb begin
        nxt = state;
        if (cs_n) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cs_fall && armed) nxt = ST_CMD;
                ST_CMD: begin
                    if (sck_rise && cnt == 5'd7) begin
                        case (cmd_byte)
                            OP_RDSR1, OP_RDID:                    nxt = ST_RESP;
                            OP_READ, OP_PP, OP_DOR, OP_QPP, OP_QOR: nxt = ST_ADDR;
                            default:                              nxt = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (sck_rise && cnt == 5'd23) begin
                        case (cmd)
                            OP_DOR, OP_QOR: nxt = ST_DUMMY;
                            OP_READ:        nxt = ST_RDATA;
                            default:        nxt = ST_WDATA;
                        endcase
                    end
                end
                ST_DUMMY: if (sck_rise && cnt == 5'd7) nxt = ST_RDATA;
                default: nxt = state;
            endcase
        end
    end

    // Output decode: lane mode, assembled words and the byte to drive next
    always_comb begin
        lanes     = op_lanes(cmd);
        nb        = lane_bits(lanes);
        cmd_byte  = {sh[6:0], io_in[0]};
        addr_full = {sh[22:0], io_in[0]};
        wr_next   = (lanes == LANE_4) ? {sh[3:0], io_in} : {sh[6:0], io_in[0]};
        bpos_next = cnt[2:0] + nb;
        resp_byte = status_byte(wel);
        if (cmd == OP_RDID) begin
            case (ridx)
                2'd0:    resp_byte = ID_VAL[23:16];
                2'd1:    resp_byte = ID_VAL[15:8];
                default: resp_byte = ID_VAL[7:0];
            endcase
        end
        if (cnt[2:0] == 3'd0) rd_val = (state == ST_RDATA) ? nxt_byte : resp_byte;
        else                  rd_val = osh;
    end

    // Datapath: shifting, lane outputs, memory requests and WEL bookkeeping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd         <= 8'h00;
            cnt         <= 5'd0;
            ridx        <= 2'd0;
            sh          <= 24'h0;
            osh         <= 8'h00;
            nxt_byte    <= 8'h00;
            rd_cap      <= 1'b0;
            wel         <= 1'b0;
            wr_txn      <= 1'b0;
            armed       <= 1'b0;
            settle      <= 2'd0;
            oe          <= 4'b0000;
            out         <= 4'b0000;
            mem_re_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= 8'h00;
        end else begin
            mem_re_o <= 1'b0;
            mem_we_o <= 1'b0;
            rd_cap   <= mem_re_o;
            if (rd_cap) nxt_byte <= mem_rdata_i;

            // A cs_n low seen straight out of reset is a stale transaction:
            // only arm once the flushed synchroniser shows cs_n high
            if (settle != 2'd3)  settle <= settle + 2'd1;
            else if (cs_n)       armed  <= 1'b1;

            // Write address advances the cycle after its strobe
            if (mem_we_o) mem_addr_o <= mem_addr_o + MEM_AW'(1);

            if (nxt == ST_IDLE) begin
                oe   <= 4'b0000;
                out  <= 4'b0000;
                cnt  <= 5'd0;
                ridx <= 2'd0;
                sh   <= 24'h0;
                if (state != ST_IDLE && wr_txn) wel <= 1'b0;
                wr_txn <= 1'b0;
            end else begin
                case (state)
                    ST_CMD, ST_ADDR, ST_DUMMY: begin
                        if (sck_rise) begin
                            sh  <= {sh[22:0], io_in[0]};
                            cnt <= cnt + 5'd1;
                            if (state == ST_CMD && cnt == 5'd7) begin
                                cmd  <= cmd_byte;
                                cnt  <= 5'd0;
                                ridx <= 2'd0;
                                if (cmd_byte == OP_WREN) wel <= 1'b1;
                                if (cmd_byte == OP_WRDI) wel <= 1'b0;
                                if (cmd_byte == OP_PP || cmd_byte == OP_QPP) wr_txn <= 1'b1;
                            end
                            if (state == ST_ADDR && cnt == 5'd23) begin
                                mem_addr_o <= addr_full[MEM_AW-1:0];
                                cnt        <= 5'd0;
                                if (cmd == OP_READ) mem_re_o <= 1'b1;
                            end
                            if (state == ST_DUMMY && cnt == 5'd7) begin
                                cnt      <= 5'd0;
                                mem_re_o <= 1'b1;
                            end
                        end
                    end
                    ST_RDATA, ST_RESP: begin
                        if (sck_fall) begin
                            out <= lane_drive(lanes, rd_val);
                            oe  <= lane_oe(lanes);
                            osh <= rd_val << nb;
                            cnt <= {2'b00, bpos_next};
                            // First bit of a byte: prefetch the following byte
                            if (cnt[2:0] == 3'd0) begin
                                if (state == ST_RDATA) begin
                                    mem_addr_o <= mem_addr_o + MEM_AW'(1);
                                    mem_re_o   <= 1'b1;
                                end else begin
                                    ridx <= (ridx == 2'd2) ? 2'd0 : ridx + 2'd1;
                                end
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sck_rise) begin
                            sh  <= {16'h0, wr_next};
                            cnt <= {2'b00, bpos_next};
                            if (bpos_next == 3'd0 && wel) begin
                                mem_we_o    <= 1'b1;
                                mem_wdata_o <= wr_next;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_slave.sv
// Directed bench for qspi_slave: status, ID, single/dual/quad read, quad write with wrap, reset mid-read.
// Latency: SCLK half period is 5 clk; io sampled 44 ns after each SCLK fall.
// Backpressure: memory model answers every read one clk later.
module tb_qspi_slave;

    logic        clk_i  = 1'b0;
    logic        rst_i  = 1'b0;
    logic        sclk_i = 1'b1;
    logic        cs_ni  = 1'b1;
    wire  [3:0]  io;
    logic        mem_re_o;
    logic        mem_we_o;
    logic [23:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i = 8'h00;

    logic [3:0]  drv_dat = 4'h0;
    logic [3:0]  drv_en  = 4'h0;

    int errors = 0;
    int checks = 0;

    int          re_cnt = 0;
    int          we_cnt = 0;
    logic [23:0] re_addr [$];
    logic [31:0] wr_log  [$];
    bit          both_seen = 1'b0;

    always #5 clk_i = ~clk_i;

    for (genvar i = 0; i < 4; i++) begin : g_drv
        assign io[i] = drv_en[i] ? drv_dat[i] : 1'bz;
    end

    qspi_slave #(
        .ID_VAL (24'h01_20_18),
        .MEM_AW (24)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sclk_i      (sclk_i),
        .cs_ni       (cs_ni),
        .io          (io),
        .mem_re_o    (mem_re_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    function automatic logic [7:0] mem_model(input logic [23:0] a);
        case (a)
            24'h000010: return 8'hA5;
            24'h000011: return 8'h3C;
            24'h0000FF: return 8'h12;
            24'h000100: return 8'h34;
            default:    return 8'h00;
        endcase
    endfunction

    // Memory model and request monitor, sampled mid-cycle
    always @(negedge clk_i) begin
        if (mem_re_o) begin
            re_cnt++;
            re_addr.push_back(mem_addr_o);
            mem_rdata_i = mem_model(mem_addr_o);
        end
        if (mem_we_o) begin
            we_cnt++;
            wr_log.push_back({mem_addr_o, mem_wdata_o});
        end
        if (mem_re_o && mem_we_o) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One SCLK period: fall, drive, sample just before rise, rise
    task automatic sclk_cyc(input logic [3:0] dat, input logic [3:0] en, output logic [3:0] smp);
        sclk_i  = 1'b0;
        drv_dat = dat;
        drv_en  = en;
        #44;
        smp = io;
        #6;
        sclk_i = 1'b1;
        #50;
    endtask

    task automatic send_bits(input logic [23:0] v, input int n);
        logic [3:0] smp;
        for (int i = n - 1; i >= 0; i--) sclk_cyc({3'b000, v[i]}, 4'b0001, smp);
    endtask

    task automatic read_bits(input int ncyc, input int lanes, output logic [31:0] v);
        logic [3:0] smp;
        v = '0;
        for (int i = 0; i < ncyc; i++) begin
            sclk_cyc(4'h0, 4'h0, smp);
            case (lanes)
                1:       v = {v[30:0], smp[1]};
                2:       v = {v[29:0], smp[1:0]};
                default: v = {v[27:0], smp};
            endcase
        end
    endtask

    task automatic cs_lo();
        cs_ni = 1'b0;
        #100;
    endtask

    task automatic cs_hi();
        #100;
        cs_ni  = 1'b1;
        drv_en = 4'h0;
        #200;
    endtask

    task automatic one_byte_cmd(input logic [7:0] op);
        cs_lo();
        send_bits({16'h0, op}, 8);
        cs_hi();
    endtask

    initial begin
        logic [31:0] v;
        logic [3:0]  smp;
        int          s_re;
        int          s_we;

        // Reset state
        #1 rst_i = 1'b1;
        #1;
        check("rst_re",    {31'h0, mem_re_o}, 32'h0);
        check("rst_we",    {31'h0, mem_we_o}, 32'h0);
        check("rst_addr",  {8'h0, mem_addr_o}, 32'h0);
        check("rst_wdata", {24'h0, mem_wdata_o}, 32'h0);
        check("rst_oe",    {28'h0, dut.oe}, 32'h0);
        #38 rst_i = 1'b0;
        #100;

        // RDSR without WREN
        cs_lo();
        send_bits(24'h05, 8);
        read_bits(8, 1, v);
        check("rdsr_nowel", v, 32'h00);
        cs_hi();

        // WREN then RDSR, two repeats
        cs_lo();
        send_bits(24'h06, 8);
        sclk_cyc(4'h0, 4'h0, smp);
        check("wren_oe", {28'h0, dut.oe}, 32'h0);
        cs_hi();
        cs_lo();
        send_bits(24'h05, 8);
        read_bits(16, 1, v);
        check("rdsr_wel", v, 32'h0202);
        cs_hi();

        // WRDI clears WEL
        one_byte_cmd(8'h04);
        cs_lo();
        send_bits(24'h05, 8);
        read_bits(8, 1, v);
        check("rdsr_wrdi", v, 32'h00);
        cs_hi();

        // PP without WREN writes nothing
        s_we = we_cnt;
        cs_lo();
        send_bits(24'h02, 8);
        send_bits(24'h000040, 24);
        send_bits(24'h55, 8);
        cs_hi();
        check("pp_nowel_we", 32'(we_cnt - s_we), 32'h0);

        // Unknown opcode stays tri-stated
        s_re = re_cnt;
        cs_lo();
        send_bits(24'hAA, 8);
        read_bits(8, 1, v);
        check("ign_oe", {28'h0, dut.oe}, 32'h0);
        check("ign_re", 32'(re_cnt - s_re), 32'h0);
        cs_hi();

        // READ 0x10: A5 then 3C on io[1]
        s_re = re_cnt;
        cs_lo();
        send_bits(24'h03, 8);
        send_bits(24'h000010, 24);
        read_bits(8, 1, v);
        check("read_b0", v, 32'hA5);
        check("read_oe", {28'h0, dut.oe}, 32'h2);
        read_bits(8, 1, v);
        check("read_b1", v, 32'h3C);
        cs_hi();
        check("read_re_ge2", {31'h0, (re_cnt - s_re) >= 2}, 32'h1);
        check("read_re_a0", {8'h0, re_addr[s_re]}, 32'h10);
        check("read_re_a1", {8'h0, re_addr[s_re + 1]}, 32'h11);

        // QOR 0xFF across a 0x100 boundary
        cs_lo();
        send_bits(24'h6B, 8);
        send_bits(24'h0000FF, 24);
        read_bits(8, 4, v);
        check("qor_dummy_oe", {28'h0, dut.oe}, 32'h0);
        read_bits(4, 4, v);
        check("qor_data", v, 32'h1234);
        check("qor_oe", {28'h0, dut.oe}, 32'hF);
        cs_hi();

        // DOR 0x10 on {io1,io0}
        cs_lo();
        send_bits(24'h3B, 8);
        send_bits(24'h000010, 24);
        read_bits(8, 2, v);
        read_bits(4, 2, v);
        check("dor_data", v, 32'hA5);
        check("dor_oe", {28'h0, dut.oe}, 32'h3);
        cs_hi();

        // QPP with address wrap, then WEL auto-clear
        one_byte_cmd(8'h06);
        s_we = we_cnt;
        cs_lo();
        send_bits(24'h32, 8);
        send_bits(24'hFFFFFF, 24);
        sclk_cyc(4'hD, 4'hF, smp);
        sclk_cyc(4'hE, 4'hF, smp);
        sclk_cyc(4'hA, 4'hF, smp);
        sclk_cyc(4'hD, 4'hF, smp);
        cs_hi();
        check("qpp_we_cnt", 32'(we_cnt - s_we), 32'h2);
        check("qpp_wr0", wr_log[s_we], 32'hFFFFFF_DE);
        check("qpp_wr1", wr_log[s_we + 1], 32'h000000_AD);
        cs_lo();
        send_bits(24'h05, 8);
        read_bits(8, 1, v);
        check("qpp_wel_clr", v, 32'h00);
        cs_hi();

        // Reset in the middle of a QOR data phase
        cs_lo();
        send_bits(24'h6B, 8);
        send_bits(24'h000010, 24);
        read_bits(8, 4, v);
        read_bits(2, 4, v);
        check("mid_qor_data", v, 32'hA5);
        check("mid_qor_oe", {28'h0, dut.oe}, 32'hF);
        rst_i = 1'b1;
        #1;
        check("rst_async_oe", {28'h0, dut.oe}, 32'h0);
        check("rst_async_addr", {8'h0, mem_addr_o}, 32'h0);
        #19 rst_i = 1'b0;
        s_re = re_cnt;
        read_bits(4, 4, v);
        check("post_rst_oe", {28'h0, dut.oe}, 32'h0);
        check("post_rst_re", 32'(re_cnt - s_re), 32'h0);
        cs_hi();

        // RDID after reset, with cyclic repeat
        cs_lo();
        send_bits(24'h9F, 8);
        read_bits(32, 1, v);
        check("rdid", v, 32'h01201801);
        cs_hi();

        check("re_we_exclusive", {31'h0, both_seen}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
